run_ctrl: RTL and testbench

//  Run/halt sequencer directly upstream of the processor core.
//  - Turns the bench-level Start/Ack handshake into core controls: CoreStart (PC load), RunEn (state-write gate), StartAddr (entry PC).
//  - Cycle-counts each program run and raises Ack on a decoded halt or on watchdog timeout.
//  - Steps through PROG_CT programs, one per Start request.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/run_ctrl_cycle_watchdog.sv | 31 +++
 rtl/run_ctrl.sv | 123 ++++++++++++
 tb/tb_run_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and program entry table for the run/halt sequencer
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } run_state_t;

    localparam int ROM_PC_W  = 10;
    localparam int ROM_SLOTS = 4;

    // Entry PC of each program image; slots past PROG_CT are never selected.
    localparam logic [ROM_PC_W-1:0] START_ADDR [ROM_SLOTS] = '{
        10'h000,
        10'h040,
        10'h120,
        10'h3F0
    };

endpackage

// File: rtl/run_ctrl_cycle_watchdog.sv
// rtl/run_ctrl_cycle_watchdog.sv - run cycle counter with terminal-count compare
module cycle_watchdog #(
    parameter int CT_W    = 16,
    parameter int TIMEOUT = 'hFFFF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear,
    input  logic            i_count_en,
    output logic [CT_W-1:0] o_count,
    output logic            o_terminal
);

    localparam logic [CT_W-1:0] LP_LAST  = CT_W'(TIMEOUT - 1);
    localparam logic [CT_W-1:0] LP_LIMIT = CT_W'(TIMEOUT);

    logic [CT_W-1:0] r_count;

    // The limit guard keeps the count pinned at TIMEOUT rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LP_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == LP_LAST);

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/halt sequencer turning Start/Ack into core start, run gate and entry PC
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CT_W    = 16,
    parameter int TIMEOUT = 'hFFFF,
    parameter int PROG_CT = 3,
    parameter int PC_W    = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_halt_req,
    output logic            o_core_start,
    output logic            o_run_en,
    output logic [1:0]      o_prog_sel,
    output logic [PC_W-1:0] o_start_addr,
    output logic            o_ack,
    output logic [CT_W-1:0] o_cycle_ct,
    output logic            o_timeout
);

    if (PROG_CT < 1 || PROG_CT > ROM_SLOTS) begin : g_bad_prog_ct
        $error("run_ctrl: PROG_CT must be 1..4 to fit the 2-bit program select");
    end

    localparam logic [1:0] LP_LAST_PROG = 2'(PROG_CT - 1);

    run_state_t r_state;
    run_state_t w_next;
    logic [1:0] r_prog_sel;
    logic       r_ack;
    logic       r_timeout;

    logic w_enter_load;
    logic w_halt_done;
    logic w_wdog_done;
    logic w_advance;
    logic w_terminal;

    cycle_watchdog #(
        .CT_W    (CT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_enter_load),
        .i_count_en (o_run_en),
        .o_count    (o_cycle_ct),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_next       = r_state;
        w_enter_load = 1'b0;
        w_halt_done  = 1'b0;
        w_wdog_done  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next       = LOAD;
                    w_enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (!i_start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                // An abort restarts the same program; a halt beats the watchdog.
                if (i_start) begin
                    w_next       = LOAD;
                    w_enter_load = 1'b1;
                end else if (i_halt_req) begin
                    w_next      = DONE;
                    w_halt_done = 1'b1;
                end else if (w_terminal) begin
                    w_next      = DONE;
                    w_wdog_done = 1'b1;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_next       = LOAD;
                    w_enter_load = 1'b1;
                    w_advance    = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        o_core_start = (r_state == LOAD);
        o_run_en     = (r_state == RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_prog_sel <= 2'd0;
            r_ack      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter_load) begin
                r_ack     <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_halt_done || w_wdog_done) begin
                r_ack     <= 1'b1;
                r_timeout <= w_wdog_done;
            end
            if (w_advance) begin
                r_prog_sel <= (r_prog_sel == LP_LAST_PROG) ? 2'd0 : r_prog_sel + 2'd1;
            end
        end
    end

    assign o_prog_sel   = r_prog_sel;
    assign o_start_addr = PC_W'(START_ADDR[r_prog_sel]);
    assign o_ack        = r_ack;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - randomized self-checking bench for run_ctrl against a run-level model
module tb_run_ctrl;

    localparam int CT_W    = 16;
    localparam int TIMEOUT = 50;
    localparam int PROG_CT = 3;
    localparam int PC_W    = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            halt_req = 1'b0;
    logic            core_start;
    logic            run_en;
    logic [1:0]      prog_sel;
    logic [PC_W-1:0] start_addr;
    logic            ack;
    logic [CT_W-1:0] cycle_ct;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    int mdl_prog = 0;
    bit mdl_done = 0;
    logic [PC_W-1:0] exp_addr [4];

    run_ctrl #(
        .CT_W    (CT_W),
        .TIMEOUT (TIMEOUT),
        .PROG_CT (PROG_CT),
        .PC_W    (PC_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_halt_req   (halt_req),
        .o_core_start (core_start),
        .o_run_en     (run_en),
        .o_prog_sel   (prog_sel),
        .o_start_addr (start_addr),
        .o_ack        (ack),
        .o_cycle_ct   (cycle_ct),
        .o_timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mdl_prog = 0;
        mdl_done = 0;
    endtask

    // One complete run: Start held k cycles, HaltReq on run cycle h (h=0: never).
    task automatic do_run(input int k, input int h, input string tag);
        int n_load = 0;
        int n_run = 0;
        int exp_run;
        bit exp_to;
        bit got_ack = 0;
        if (mdl_done) mdl_prog = (mdl_prog + 1) % PROG_CT;
        exp_to  = !(h >= 1 && h <= TIMEOUT);
        exp_run = exp_to ? TIMEOUT : h;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (ack && n_run > 0) begin
                got_ack = 1;
                break;
            end
            start = (cyc < k);
            if (core_start) begin
                n_load++;
                checks++;
                if (prog_sel !== 2'(mdl_prog) || start_addr !== exp_addr[mdl_prog]) begin
                    errors++;
                    $display("FAIL %s prog_sel/start_addr: got %0d/%h expected %0d/%h",
                             tag, prog_sel, start_addr, mdl_prog, exp_addr[mdl_prog]);
                end
            end
            if (run_en) begin
                n_run++;
                halt_req = (n_run == h);
            end else begin
                halt_req = 1'($urandom_range(0, 1));
            end
            step();
        end
        start = 0;
        halt_req = 0;
        mdl_done = 1;
        checks++;
        if (!got_ack) begin
            errors++;
            $display("FAIL %s ack_wait: got no ack within budget, required ack=1", tag);
        end
        checks++;
        if (n_load != k || n_run != exp_run) begin
            errors++;
            $display("FAIL %s load/run cycles: got %0d/%0d expected %0d/%0d", tag, n_load, n_run, k, exp_run);
        end
        checks++;
        if (cycle_ct !== CT_W'(exp_run) || timeout !== exp_to || run_en !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL %s done_state: got ct=%0d to=%b run=%b cs=%b expected ct=%0d to=%b run=0 cs=0",
                     tag, cycle_ct, timeout, run_en, core_start, exp_run, exp_to);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        checks++;
        if (ack !== 1'b0 || prog_sel !== 2'd0 || core_start !== 1'b0 || run_en !== 1'b0 ||
            cycle_ct !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: got ack=%b ps=%0d cs=%b run=%b ct=%0d to=%b expected all zero",
                     ack, prog_sel, core_start, run_en, cycle_ct, timeout);
        end
        reset = 1'b0;
        start = 1'b0;
        mdl_prog = 0;
        mdl_done = 0;
        step();
        checks++;
        if (core_start !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got cs=%b ack=%b expected 0/0", core_start, ack);
        end
    endtask

    task automatic test_halt_run();
        do_run(3, 20, "halt_run");
    endtask

    task automatic test_watchdog();
        logic [CT_W-1:0] held_ct;
        bit stable = 1;
        do_run(1, 0, "watchdog");
        held_ct = cycle_ct;
        for (int i = 0; i < 6; i++) begin
            halt_req = 1'($urandom_range(0, 1));
            step();
            if (cycle_ct !== held_ct || ack !== 1'b1 || timeout !== 1'b1 || run_en !== 1'b0) stable = 0;
        end
        halt_req = 0;
        checks++;
        if (!stable || held_ct !== CT_W'(TIMEOUT)) begin
            errors++;
            $display("FAIL watchdog_frozen: got ct=%0d ack=%b to=%b expected ct=%0d ack=1 to=1",
                     cycle_ct, ack, timeout, TIMEOUT);
        end
    endtask

    task automatic test_prog_wrap();
        int seen [4];
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            do_run(1 + r % 2, 5 + r, "prog_wrap");
            seen[r] = mdl_prog;
        end
        checks++;
        if (seen[0] != 0 || seen[1] != 1 || seen[2] != 2 || seen[3] != 0 || prog_sel !== 2'd0) begin
            errors++;
            $display("FAIL prog_wrap_seq: got final prog_sel=%0d expected sequence 0,1,2,0 ending at 0", prog_sel);
        end
    endtask

    task automatic test_halt_at_limit();
        do_run(2, TIMEOUT, "halt_at_limit");
        checks++;
        if (ack !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL halt_at_limit_flags: got ack=%b to=%b expected 1/0", ack, timeout);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        bit got_ack = 0;
        if (mdl_done) mdl_prog = (mdl_prog + 1) % PROG_CT;
        start = 1;
        step();
        start = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (run_en) n++;
            if (n == 5) begin
                start = 1;
                step();
                break;
            end
            step();
        end
        start = 0;
        checks++;
        if (core_start !== 1'b1 || prog_sel !== 2'(mdl_prog) || cycle_ct !== '0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_reload: got cs=%b ps=%0d ct=%0d ack=%b expected 1/%0d/0/0",
                     core_start, prog_sel, cycle_ct, ack, mdl_prog);
        end
        n = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (ack) begin
                got_ack = 1;
                break;
            end
            if (run_en) n++;
            halt_req = run_en && (n == 10);
            step();
        end
        halt_req = 0;
        mdl_done = 1;
        checks++;
        if (!got_ack || cycle_ct !== CT_W'(10) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun: got ack=%b ct=%0d to=%b expected 1/10/0", got_ack, cycle_ct, timeout);
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        start = 1;
        step();
        step();
        start = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (run_en) n++;
            if (n == 7) break;
            step();
        end
        reset = 1;
        step();
        reset = 0;
        mdl_prog = 0;
        mdl_done = 0;
        checks++;
        if (run_en !== 1'b0 || cycle_ct !== '0 || prog_sel !== 2'd0 || ack !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got run=%b ct=%0d ps=%0d ack=%b cs=%b expected all zero",
                     run_en, cycle_ct, prog_sel, ack, core_start);
        end
        step();
        step();
        do_run(2, 15, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int k = $urandom_range(1, 4);
            int h = $urandom_range(0, TIMEOUT + 10);
            do_run(k, h, "random");
        end
    endtask

    initial begin
        exp_addr[0] = 10'h000;
        exp_addr[1] = 10'h040;
        exp_addr[2] = 10'h120;
        exp_addr[3] = 10'h3F0;
        test_reset();
        test_halt_run();
        test_watchdog();
        test_prog_wrap();
        test_halt_at_limit();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
